// File: rtl/shift_wb_fifo.sv
// Two-entry writeback FIFO behind the barrel shifter: captures each result with its
// destination tag and N/Z/C flags, and presents the oldest entry to writeback.
module shift_wb_fifo #(
    parameter int TAGW = 3
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      shift_type,
    input  logic [3:0]      shift,
    input  logic [15:0]     data_in,
    input  logic [15:0]     data_out,
    input  logic [TAGW-1:0] rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic [TAGW-1:0] out_rd,
    output logic            out_n,
    output logic            out_z,
    output logic            out_c
);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    typedef struct packed {
        logic [15:0]     data;
        logic [TAGW-1:0] rd;
        logic            n;
        logic            z;
        logic            c;
    } entry_t;

    entry_t     mem [2];
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       carry;
    entry_t     new_entry;

    // Carry is the last bit shifted out of the operand; a zero shift shifts nothing out.
    always_comb begin
        // NOTE: default first so every path assigns carry and no latch is inferred.
        carry = 1'b0;
        if (shift != 4'd0) begin
            case (shift_op_e'(shift_type))
                SH_LSL:         carry = data_in[4'(5'd16 - {1'b0, shift})];
                SH_LSR, SH_ASR: carry = data_in[shift - 4'd1];
                SH_ROR:         carry = data_out[15];
                default:        carry = 1'b0;
            endcase
        end
    end

    assign new_entry = '{data: data_out, rd: rd, n: data_out[15],
                         z: (data_out == 16'h0000), c: carry};

    // Handshakes depend only on registered count, so in_ready never sees out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            // NOTE: non-blocking assignments for all sequential state.
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; stale contents are never visible because outputs are gated by out_valid.
    always_ff @(posedge Clock) begin
        if (push && !flush) mem[tail] <= new_entry;
    end

    always_comb begin
        {out_data, out_rd, out_n, out_z, out_c} = '0;
        if (out_valid) {out_data, out_rd, out_n, out_z, out_c} = mem[head];
    end

endmodule

// File: tb/tb_shift_wb_fifo.sv
// Bench for shift_wb_fifo: directed vector table, flush/reset sequences, and
// randomized traffic against a queue-based reference model.
module tb_shift_wb_fifo;

    logic        Clock;
    logic        Reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  shift_type;
    logic [3:0]  shift;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [2:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_rd;
    logic        out_n;
    logic        out_z;
    logic        out_c;

    int checks   = 0;
    int failures = 0;

    shift_wb_fifo #(.TAGW(3)) dut (
        .Clock(Clock), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .shift_type(shift_type), .shift(shift),
        .data_in(data_in), .data_out(data_out), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd),
        .out_n(out_n), .out_z(out_z), .out_c(out_c)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
        logic        n;
        logic        z;
        logic        c;
    } m_entry_t;

    m_entry_t q[$];

    typedef struct {
        logic        fl;
        logic        iv;
        logic [1:0]  st;
        logic [3:0]  sh;
        logic [15:0] di;
        logic [15:0] dout;
        logic [2:0]  rd;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [15:0] e_data;
        logic [2:0]  e_rd;
        logic        e_n;
        logic        e_z;
        logic        e_c;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic fl, logic iv, logic [1:0] st, logic [3:0] sh,
                                logic [15:0] di, logic [15:0] dout, logic [2:0] r,
                                logic ordy, logic e_ov, logic e_ir, logic [15:0] e_data,
                                logic [2:0] e_rd, logic e_n, logic e_z, logic e_c);
        vec_t v;
        v.fl = fl; v.iv = iv; v.st = st; v.sh = sh; v.di = di; v.dout = dout;
        v.rd = r; v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir; v.e_data = e_data;
        v.e_rd = e_rd; v.e_n = e_n; v.e_z = e_z; v.e_c = e_c;
        return v;
    endfunction

    // Reference barrel shifter, used only to produce realistic upstream data_out.
    function automatic logic [15:0] barrel(logic [1:0] t, logic [3:0] s, logic [15:0] d);
        int unsigned x;
        int          sh;
        x  = 32'(d);
        sh = int'(s);
        case (t)
            2'd0:    return 16'(x << sh);
            2'd1:    return 16'(x >> sh);
            2'd2:    return 16'($signed({{16{d[15]}}, d}) >>> sh);
            default: return 16'((x >> sh) | (x << (16 - sh)));
        endcase
    endfunction

    function automatic logic model_carry(logic [1:0] t, logic [3:0] s, logic [15:0] di,
                                         logic [15:0] dout);
        int unsigned x;
        int          sh;
        x  = 32'(di);
        sh = int'(s);
        if (sh == 0) return 1'b0;
        case (t)
            2'd0:       return 1'((x >> (16 - sh)) & 1);
            2'd1, 2'd2: return 1'((x >> (sh - 1)) & 1);
            default:    return dout[15];
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_outs(string tag, logic ov, logic ir, logic [15:0] d,
                                logic [2:0] r, logic n, logic z, logic c);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        check({tag, ".out_data"},  32'(out_data),  32'(d));
        check({tag, ".out_rd"},    32'(out_rd),    32'(r));
        check({tag, ".out_n"},     32'(out_n),     32'(n));
        check({tag, ".out_z"},     32'(out_z),     32'(z));
        check({tag, ".out_c"},     32'(out_c),     32'(c));
    endtask

    task automatic compare_model(string tag);
        if (q.size() == 0)
            compare_outs(tag, 1'b0, 1'b1, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);
        else
            compare_outs(tag, 1'b1, q.size() != 2, q[0].data, q[0].rd,
                         q[0].n, q[0].z, q[0].c);
    endtask

    task automatic drive(logic fl, logic iv, logic [1:0] st, logic [3:0] sh,
                         logic [15:0] di, logic [15:0] dout, logic [2:0] r, logic ordy);
        flush = fl; in_valid = iv; shift_type = st; shift = sh;
        data_in = di; data_out = dout; rd = r; out_ready = ordy;
    endtask

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic step();
        int       pre;
        bit       do_pop;
        bit       do_push;
        m_entry_t e;
        pre     = q.size();
        do_pop  = (pre != 0) && out_ready;
        do_push = in_valid && (pre != 2);
        e.data  = data_out;
        e.rd    = rd;
        e.n     = data_out[15];
        e.z     = (data_out == 16'h0000);
        e.c     = model_carry(shift_type, shift, data_in, data_out);
        @(posedge Clock);
        if (Reset || flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(logic ordy);
        drive(1'b0, 1'b0, 2'd0, 4'd0, 16'h0, 16'h0, 3'd0, ordy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0,1,2'd0,4'd4, 16'h8421,16'h4210,3'd1,0, 1,1,16'h4210,3'd1,0,0,0);
        vecs[1]  = mk(0,0,2'd0,4'd0, 16'h0000,16'h0000,3'd0,1, 0,1,16'h0000,3'd0,0,0,0);
        vecs[2]  = mk(0,1,2'd2,4'd1, 16'h8001,16'hC000,3'd2,0, 1,1,16'hC000,3'd2,1,0,1);
        vecs[3]  = mk(0,1,2'd1,4'd1, 16'h0001,16'h0000,3'd3,0, 1,0,16'hC000,3'd2,1,0,1);
        vecs[4]  = mk(0,1,2'd0,4'd1, 16'h1234,16'h2468,3'd4,0, 1,0,16'hC000,3'd2,1,0,1);
        vecs[5]  = mk(0,0,2'd0,4'd0, 16'h0000,16'h0000,3'd0,1, 1,1,16'h0000,3'd3,0,1,1);
        vecs[6]  = mk(0,0,2'd0,4'd0, 16'h0000,16'h0000,3'd0,1, 0,1,16'h0000,3'd0,0,0,0);
        vecs[7]  = mk(0,1,2'd3,4'd8, 16'h12AB,16'hAB12,3'd5,1, 1,1,16'hAB12,3'd5,1,0,1);
        vecs[8]  = mk(0,1,2'd0,4'd0, 16'h7FFF,16'h7FFF,3'd6,1, 1,1,16'h7FFF,3'd6,0,0,0);
        vecs[9]  = mk(0,1,2'd0,4'd15,16'h0003,16'h8000,3'd7,0, 1,0,16'h7FFF,3'd6,0,0,0);
        vecs[10] = mk(0,1,2'd1,4'd2, 16'hFFFF,16'h3FFF,3'd0,1, 1,1,16'h8000,3'd7,1,0,1);
        vecs[11] = mk(0,0,2'd0,4'd0, 16'h0000,16'h0000,3'd0,1, 0,1,16'h0000,3'd0,0,0,0);

        Reset = 1'b1;
        idle(1'b0);
        step();
        compare_outs("reset", 1'b0, 1'b1, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].st, vecs[i].sh, vecs[i].di,
                  vecs[i].dout, vecs[i].rd, vecs[i].ordy);
            step();
            compare_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_data,
                         vecs[i].e_rd, vecs[i].e_n, vecs[i].e_z, vecs[i].e_c);
        end

        // Flush while full with a push attempt: nothing survives.
        drive(0, 1, 2'd0, 4'd1, 16'h0101, 16'h0202, 3'd1, 0); step();
        drive(0, 1, 2'd0, 4'd2, 16'h0101, 16'h0404, 3'd2, 0); step();
        check("flush_pre.in_ready", 32'(in_ready), 32'd0);
        drive(1, 1, 2'd0, 4'd3, 16'h0101, 16'h0808, 3'd3, 1); step();
        compare_outs("flush_full", 1'b0, 1'b1, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0); step();
        compare_outs("flush_full_after", 1'b0, 1'b1, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);

        // Flush with one entry and an otherwise-acceptable push.
        drive(0, 1, 2'd1, 4'd4, 16'hF000, 16'h0F00, 3'd4, 0); step();
        drive(1, 1, 2'd1, 4'd4, 16'hF000, 16'h0F00, 3'd5, 0); step();
        compare_outs("flush_one", 1'b0, 1'b1, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0); step();
        compare_model("flush_one_after");

        // Reset asserted between edges while full takes effect immediately.
        drive(0, 1, 2'd0, 4'd1, 16'h1111, 16'h2222, 3'd1, 0); step();
        drive(0, 1, 2'd0, 4'd1, 16'h3333, 16'h6666, 3'd2, 0); step();
        idle(1'b0);
        #3;
        Reset = 1'b1;
        #1;
        compare_outs("async_reset", 1'b0, 1'b1, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);
        q.delete();
        step();
        Reset = 1'b0;
        drive(0, 1, 2'd2, 4'd3, 16'h8008, 16'hF001, 3'd6, 0); step();
        compare_outs("post_reset_first", 1'b1, 1'b1, 16'hF001, 3'd6, 1'b1, 1'b0, 1'b0);
        idle(1'b1); step();
        compare_model("post_reset_drain");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 500; i++) begin
            logic [1:0]  st;
            logic [3:0]  sh;
            logic [15:0] di;
            st = 2'($urandom_range(0, 3));
            sh = 4'($urandom_range(0, 15));
            di = 16'($urandom);
            if ($urandom_range(0, 7) == 0) di = 16'h0000;
            drive($urandom_range(0, 24) == 0, 1'($urandom), st, sh, di,
                  barrel(st, sh, di), 3'($urandom), $urandom_range(0, 2) != 0);
            step();
            compare_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
